// File: rtl/tl_ul_arbiter.sv
// N:1 TileLink-UL arbiter: round-robin channel A with a grant lock while a beat is stalled,
// channel D demultiplexed on a requester-index prefix of the source ID.
module tl_ul_arbiter #(
    parameter int NREQ    = 2,
    parameter int TL_RS   = 4,
    parameter int AW      = 16,
    parameter int MAX_OUT = 4
) (
    input  logic                            arb_clock_i,
    input  logic                            arb_reset_i,
    input  logic [NREQ*3-1:0]               s_a_opcode,
    input  logic [NREQ*3-1:0]               s_a_param,
    input  logic [NREQ*4-1:0]               s_a_size,
    input  logic [NREQ*TL_RS-1:0]           s_a_source,
    input  logic [NREQ*AW-1:0]              s_a_address,
    input  logic [NREQ*4-1:0]               s_a_mask,
    input  logic [NREQ*32-1:0]              s_a_data,
    input  logic [NREQ-1:0]                 s_a_valid,
    output logic [NREQ-1:0]                 s_a_ready,
    output logic [NREQ*3-1:0]               s_d_opcode,
    output logic [NREQ*2-1:0]               s_d_param,
    output logic [NREQ*4-1:0]               s_d_size,
    output logic [NREQ*TL_RS-1:0]           s_d_source,
    output logic [NREQ-1:0]                 s_d_denied,
    output logic [NREQ*32-1:0]              s_d_data,
    output logic [NREQ-1:0]                 s_d_corrupt,
    output logic [NREQ-1:0]                 s_d_valid,
    input  logic [NREQ-1:0]                 s_d_ready,
    output logic [2:0]                      m_a_opcode,
    output logic [2:0]                      m_a_param,
    output logic [3:0]                      m_a_size,
    output logic [AW-1:0]                   m_a_address,
    output logic [3:0]                      m_a_mask,
    output logic [31:0]                     m_a_data,
    output logic [TL_RS+$clog2(NREQ)-1:0]   m_a_source,
    output logic                            m_a_valid,
    input  logic                            m_a_ready,
    input  logic [2:0]                      m_d_opcode,
    input  logic [1:0]                      m_d_param,
    input  logic [3:0]                      m_d_size,
    input  logic                            m_d_denied,
    input  logic [31:0]                     m_d_data,
    input  logic                            m_d_corrupt,
    input  logic [TL_RS+$clog2(NREQ)-1:0]   m_d_source,
    input  logic                            m_d_valid,
    output logic                            m_d_ready
);
    localparam int IW = $clog2(NREQ);
    localparam int SW = TL_RS + IW;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
    localparam logic [IW:0]   NREQ_W   = (IW+1)'(NREQ);
    localparam logic [CW-1:0] MAX_W    = CW'(MAX_OUT);

    logic [2:0]       a_opcode  [NREQ];
    logic [2:0]       a_param   [NREQ];
    logic [3:0]       a_size    [NREQ];
    logic [TL_RS-1:0] a_source  [NREQ];
    logic [AW-1:0]    a_address [NREQ];
    logic [3:0]       a_mask    [NREQ];
    logic [31:0]      a_data    [NREQ];

    logic [NREQ-1:0] elig;
    logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0]   lock_idx_reg, lock_idx_next;
    logic            lock_reg, lock_next;
    logic [IW-1:0]   scan_idx, scan_win, win;
    logic            any_elig, a_fire;
    logic [IW-1:0]   d_idx;
    logic            d_ok, d_fire;

    // Round-robin scan starting at rr_ptr; a stalled beat keeps its grant regardless.
    always_comb begin
        scan_idx = rr_ptr_reg;
        scan_win = rr_ptr_reg;
        any_elig = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_elig && elig[scan_idx]) begin
                any_elig = 1'b1;
                scan_win = scan_idx;
            end
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + IW'(1);
        end
    end

    assign win       = lock_reg ? lock_idx_reg : scan_win;
    assign m_a_valid = ~arb_reset_i & (lock_reg | any_elig);
    assign a_fire    = m_a_valid & m_a_ready;

    assign m_a_opcode  = a_opcode[win];
    assign m_a_param   = a_param[win];
    assign m_a_size    = a_size[win];
    assign m_a_address = a_address[win];
    assign m_a_mask    = a_mask[win];
    assign m_a_data    = a_data[win];
    assign m_a_source  = {win, a_source[win]};

    assign lock_next     = m_a_valid & ~m_a_ready;
    assign lock_idx_next = lock_next ? win : lock_idx_reg;
    assign rr_ptr_next   = a_fire ? ((win == LAST_IDX) ? '0 : win + IW'(1)) : rr_ptr_reg;

    always_ff @(posedge arb_clock_i or posedge arb_reset_i) begin
        if (arb_reset_i) begin
            lock_reg     <= 1'b0;
            lock_idx_reg <= '0;
            rr_ptr_reg   <= '0;
        end else begin
            lock_reg     <= lock_next;
            lock_idx_reg <= lock_idx_next;
            rr_ptr_reg   <= rr_ptr_next;
        end
    end

    // Responses carrying an out-of-range prefix are sunk so the slave never wedges.
    assign d_idx     = m_d_source[SW-1:TL_RS];
    assign d_ok      = ({1'b0, d_idx} < NREQ_W);
    assign m_d_ready = ~arb_reset_i & (d_ok ? s_d_ready[d_idx] : 1'b1);
    assign d_fire    = m_d_valid & m_d_ready & d_ok;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        logic [CW-1:0] cnt_reg, cnt_next;
        logic          up, dn;

        assign a_opcode[gi]  = s_a_opcode[3*gi +: 3];
        assign a_param[gi]   = s_a_param[3*gi +: 3];
        assign a_size[gi]    = s_a_size[4*gi +: 4];
        assign a_source[gi]  = s_a_source[TL_RS*gi +: TL_RS];
        assign a_address[gi] = s_a_address[AW*gi +: AW];
        assign a_mask[gi]    = s_a_mask[4*gi +: 4];
        assign a_data[gi]    = s_a_data[32*gi +: 32];

        assign elig[gi]      = s_a_valid[gi] & (cnt_reg < MAX_W);
        assign s_a_ready[gi] = a_fire & (win == IW'(gi));

        assign s_d_valid[gi]              = ~arb_reset_i & m_d_valid & d_ok & (d_idx == IW'(gi));
        assign s_d_opcode[3*gi +: 3]      = m_d_opcode;
        assign s_d_param[2*gi +: 2]       = m_d_param;
        assign s_d_size[4*gi +: 4]        = m_d_size;
        assign s_d_source[TL_RS*gi +: TL_RS] = m_d_source[TL_RS-1:0];
        assign s_d_denied[gi]             = m_d_denied;
        assign s_d_data[32*gi +: 32]      = m_d_data;
        assign s_d_corrupt[gi]            = m_d_corrupt;

        assign up = s_a_ready[gi];
        assign dn = d_fire & (d_idx == IW'(gi));

        always_comb begin
            cnt_next = cnt_reg;
            if (up && !dn)
                cnt_next = cnt_reg + CW'(1);
            else if (dn && !up && cnt_reg != '0)
                cnt_next = cnt_reg - CW'(1);
        end

        always_ff @(posedge arb_clock_i or posedge arb_reset_i) begin
            if (arb_reset_i)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_next;
        end

        // A response with nothing outstanding is a slave protocol error.
        a_no_underflow: assert property (@(posedge arb_clock_i) disable iff (arb_reset_i)
            !(dn && !up && cnt_reg == '0));
    end

endmodule

// File: tb/tb_tl_ul_arbiter.sv
// Randomized bench for tl_ul_arbiter: directed scenarios with literal checks, then random
// traffic, all outputs compared every cycle against a queue/counter model of the arbiter.
module tb_tl_ul_arbiter;
    localparam int NREQ    = 2;
    localparam int TL_RS   = 4;
    localparam int AW      = 16;
    localparam int MAX_OUT = 4;
    localparam int SW      = TL_RS + $clog2(NREQ);

    logic clk;
    logic rst;

    logic [NREQ*3-1:0]     s_a_opcode, s_a_param;
    logic [NREQ*4-1:0]     s_a_size, s_a_mask;
    logic [NREQ*TL_RS-1:0] s_a_source;
    logic [NREQ*AW-1:0]    s_a_address;
    logic [NREQ*32-1:0]    s_a_data;
    logic [NREQ-1:0]       a_valid, s_a_ready;
    logic [NREQ*3-1:0]     s_d_opcode;
    logic [NREQ*2-1:0]     s_d_param;
    logic [NREQ*4-1:0]     s_d_size;
    logic [NREQ*TL_RS-1:0] s_d_source;
    logic [NREQ-1:0]       s_d_denied, s_d_corrupt, s_d_valid, s_d_ready;
    logic [NREQ*32-1:0]    s_d_data;
    logic [2:0]  m_a_opcode, m_a_param;
    logic [3:0]  m_a_size, m_a_mask;
    logic [AW-1:0] m_a_address;
    logic [31:0] m_a_data;
    logic [SW-1:0] m_a_source;
    logic        m_a_valid, m_a_ready;
    logic [2:0]  m_d_opcode;
    logic [1:0]  m_d_param;
    logic [3:0]  m_d_size;
    logic        m_d_denied, m_d_corrupt, m_d_valid, m_d_ready;
    logic [31:0] m_d_data;
    logic [SW-1:0] m_d_source;

    logic [2:0]       a_op   [NREQ];
    logic [2:0]       a_par  [NREQ];
    logic [3:0]       a_sz   [NREQ];
    logic [TL_RS-1:0] a_src  [NREQ];
    logic [AW-1:0]    a_addr [NREQ];
    logic [3:0]       a_msk  [NREQ];
    logic [31:0]      a_dat  [NREQ];

    int errors;
    int checks;

    tl_ul_arbiter #(.NREQ(NREQ), .TL_RS(TL_RS), .AW(AW), .MAX_OUT(MAX_OUT)) dut (
        .arb_clock_i(clk), .arb_reset_i(rst),
        .s_a_opcode(s_a_opcode), .s_a_param(s_a_param), .s_a_size(s_a_size),
        .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_mask(s_a_mask),
        .s_a_data(s_a_data), .s_a_valid(a_valid), .s_a_ready(s_a_ready),
        .s_d_opcode(s_d_opcode), .s_d_param(s_d_param), .s_d_size(s_d_size),
        .s_d_source(s_d_source), .s_d_denied(s_d_denied), .s_d_data(s_d_data),
        .s_d_corrupt(s_d_corrupt), .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
        .m_a_opcode(m_a_opcode), .m_a_param(m_a_param), .m_a_size(m_a_size),
        .m_a_address(m_a_address), .m_a_mask(m_a_mask), .m_a_data(m_a_data),
        .m_a_source(m_a_source), .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
        .m_d_opcode(m_d_opcode), .m_d_param(m_d_param), .m_d_size(m_d_size),
        .m_d_denied(m_d_denied), .m_d_data(m_d_data), .m_d_corrupt(m_d_corrupt),
        .m_d_source(m_d_source), .m_d_valid(m_d_valid), .m_d_ready(m_d_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        s_a_opcode = '0; s_a_param = '0; s_a_size = '0; s_a_source = '0;
        s_a_address = '0; s_a_mask = '0; s_a_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            s_a_opcode[3*i +: 3]          = a_op[i];
            s_a_param[3*i +: 3]           = a_par[i];
            s_a_size[4*i +: 4]            = a_sz[i];
            s_a_source[TL_RS*i +: TL_RS]  = a_src[i];
            s_a_address[AW*i +: AW]       = a_addr[i];
            s_a_mask[4*i +: 4]            = a_msk[i];
            s_a_data[32*i +: 32]          = a_dat[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int cnt_m [NREQ];     // requests in flight per requester
    int last_m;           // requester granted most recently
    int held_m;           // requester whose beat is stalled downstream, -1 if none
    int pend_q [$];       // outstanding downstream source IDs
    logic [NREQ-1:0] a_hold;
    logic            d_hold;

    always @(negedge clk) begin
        int w, r, c, cand;
        logic mv, mdr, afire, dfire, found;
        logic [NREQ-1:0] sar, sdv;
        if (rst) begin
            chk("rst_m_a_valid", 64'(m_a_valid), 64'd0);
            chk("rst_s_a_ready", 64'(s_a_ready), 64'd0);
            chk("rst_s_d_valid", 64'(s_d_valid), 64'd0);
            chk("rst_m_d_ready", 64'(m_d_ready), 64'd0);
            for (int i = 0; i < NREQ; i++) cnt_m[i] = 0;
            last_m = NREQ - 1;
            held_m = -1;
            pend_q.delete();
            a_hold = '0;
            d_hold = 1'b0;
        end else begin
            mv = 1'b0;
            w  = 0;
            if (held_m >= 0) begin
                mv = 1'b1;
                w  = held_m;
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    cand = (last_m + k) % NREQ;
                    if (!mv && a_valid[cand] && cnt_m[cand] < MAX_OUT) begin
                        mv = 1'b1;
                        w  = cand;
                    end
                end
            end
            sar = '0;
            if (mv && m_a_ready) sar[w] = 1'b1;
            r = int'(m_d_source[SW-1:TL_RS]);
            sdv = '0;
            mdr = 1'b1;
            if (r < NREQ) begin
                mdr = s_d_ready[r];
                sdv[r] = m_d_valid;
            end

            chk("m_a_valid", 64'(m_a_valid), 64'(mv));
            chk("s_a_ready", 64'(s_a_ready), 64'(sar));
            if (mv) begin
                chk("m_a_source", 64'(m_a_source), 64'(w * (1 << TL_RS) + int'(a_src[w])));
                chk("m_a_fields", 64'({m_a_opcode, m_a_param, m_a_size, m_a_address, m_a_mask}),
                    64'({a_op[w], a_par[w], a_sz[w], a_addr[w], a_msk[w]}));
                chk("m_a_data", 64'(m_a_data), 64'(a_dat[w]));
            end
            chk("m_d_ready", 64'(m_d_ready), 64'(mdr));
            chk("s_d_valid", 64'(s_d_valid), 64'(sdv));
            if (m_d_valid && r < NREQ) begin
                chk("s_d_fields", 64'({s_d_opcode[3*r +: 3], s_d_param[2*r +: 2], s_d_size[4*r +: 4],
                                       s_d_denied[r], s_d_corrupt[r], s_d_source[TL_RS*r +: TL_RS]}),
                    64'({m_d_opcode, m_d_param, m_d_size, m_d_denied, m_d_corrupt, m_d_source[TL_RS-1:0]}));
                chk("s_d_data", 64'(s_d_data[32*r +: 32]), 64'(m_d_data));
            end

            afire = mv & m_a_ready;
            dfire = m_d_valid & mdr & (r < NREQ);
            if (afire) begin
                last_m = w;
                held_m = -1;
                pend_q.push_back(w * (1 << TL_RS) + int'(a_src[w]));
            end else if (mv) begin
                held_m = w;
            end
            if (!(afire && dfire && r == w)) begin
                if (afire) cnt_m[w]++;
                if (dfire && cnt_m[r] > 0) cnt_m[r]--;
            end
            if (dfire) begin
                found = 1'b0;
                c = 0;
                for (int k = 0; k < pend_q.size(); k++)
                    if (!found && pend_q[k] == int'(m_d_source)) begin
                        found = 1'b1;
                        c = k;
                    end
                if (found) pend_q.delete(c);
            end
            a_hold = a_valid & ~sar;
            d_hold = m_d_valid & ~mdr;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int i, input logic [2:0] op, input logic [3:0] src,
                         input logic [15:0] addr, input logic [31:0] data);
        a_valid[i] = 1'b1;
        a_op[i]    = op;
        a_par[i]   = 3'd0;
        a_sz[i]    = 4'd2;
        a_src[i]   = src;
        a_addr[i]  = addr;
        a_msk[i]   = 4'hF;
        a_dat[i]   = data;
    endtask

    task automatic d_resp(input int src);
        int n;
        n = 0;
        m_d_valid  = 1'b1;
        m_d_opcode = 3'd0;
        m_d_source = SW'(src);
        m_d_data   = $urandom;
        s_d_ready  = '1;
        #2;
        while (!m_d_ready && n < 8) begin
            step();
            #2;
            n++;
        end
        chk("d_resp_handshake", 64'(m_d_ready), 64'd1);
        step();
        m_d_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (pend_q.size() > 0 && guard < 40) begin
            d_resp(pend_q[0]);
            guard++;
        end
    endtask

    initial begin
        int k;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        a_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_op[i] = '0; a_par[i] = '0; a_sz[i] = '0; a_src[i] = '0;
            a_addr[i] = '0; a_msk[i] = '0; a_dat[i] = '0;
        end
        m_a_ready = 1'b0;
        m_d_opcode = '0; m_d_param = '0; m_d_size = '0; m_d_denied = 1'b0;
        m_d_data = '0; m_d_corrupt = 1'b0; m_d_source = '0; m_d_valid = 1'b0;
        s_d_ready = '0;
        repeat (3) step();
        rst = 1'b0;

        // Single PutFullData from requester 0 and its AccessAck
        set_a(0, 3'd0, 4'h3, 16'h4000, 32'hA5A5A5A5);
        m_a_ready = 1'b1;
        #2;
        chk("t1_m_a_valid", 64'(m_a_valid), 64'd1);
        chk("t1_m_a_source", 64'(m_a_source), 64'h03);
        chk("t1_m_a_address", 64'(m_a_address), 64'h4000);
        chk("t1_m_a_data", 64'(m_a_data), 64'hA5A5A5A5);
        step();
        a_valid[0] = 1'b0;
        m_d_valid = 1'b1; m_d_opcode = 3'd0; m_d_source = 5'h03; s_d_ready = '1;
        #2;
        chk("t1_s_d_valid", 64'(s_d_valid), 64'b01);
        chk("t1_s_d_source", 64'(s_d_source[3:0]), 64'h3);
        step();
        m_d_valid = 1'b0;

        // Alternation: one requester-1 beat moves the pointer back to 0
        set_a(1, 3'd4, 4'h5, 16'h0100, 32'h0);
        step();
        set_a(0, 3'd4, 4'h3, 16'h0200, 32'h0);
        for (int c = 0; c < 4; c++) begin
            #2;
            chk("t2_alternate", 64'(s_a_ready), (c % 2 == 0) ? 64'b01 : 64'b10);
            step();
        end
        a_valid = '0;
        drain();

        // Stall on requester 1 while requester 0 waits
        set_a(0, 3'd4, 4'h3, 16'h0300, 32'h0);
        step();
        m_a_ready = 1'b0;
        set_a(1, 3'd0, 4'h5, 16'h1234, 32'hDEADBEEF);
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("t3_stall_source", 64'(m_a_source), 64'h15);
            chk("t3_stall_address", 64'(m_a_address), 64'h1234);
            chk("t3_stall_ready", 64'(s_a_ready), 64'd0);
            step();
        end
        m_a_ready = 1'b1;
        #2;
        chk("t3_accept_r1", 64'(s_a_ready), 64'b10);
        chk("t3_accept_data", 64'(m_a_data), 64'hDEADBEEF);
        step();
        a_valid[1] = 1'b0;
        #2;
        chk("t3_then_r0_src", 64'(m_a_source), 64'h03);
        chk("t3_then_r0_rdy", 64'(s_a_ready), 64'b01);
        step();
        a_valid = '0;
        drain();

        // Outstanding limit on requester 0
        set_a(0, 3'd4, 4'h3, 16'h0400, 32'h0);
        for (int c = 0; c < MAX_OUT; c++) begin
            #2;
            chk("t4_get_accept", 64'(s_a_ready), 64'b01);
            step();
        end
        set_a(1, 3'd4, 4'h5, 16'h0500, 32'h0);
        #2;
        chk("t4_r1_granted", 64'(s_a_ready), 64'b10);
        step();
        a_valid[1] = 1'b0;
        m_d_valid = 1'b1; m_d_source = 5'h03; s_d_ready = '1;
        #2;
        chk("t4_r0_blocked", 64'(m_a_valid), 64'd0);
        chk("t4_d_to_r0", 64'(s_d_valid), 64'b01);
        step();
        m_d_valid = 1'b0;
        #2;
        chk("t4_fifth_accept", 64'(s_a_ready), 64'b01);
        step();
        a_valid = '0;

        // D backpressure from requester 1
        m_d_valid = 1'b1; m_d_source = 5'h15; s_d_ready = 2'b01;
        #2;
        chk("t5_m_d_ready_low", 64'(m_d_ready), 64'd0);
        chk("t5_s_d_valid", 64'(s_d_valid), 64'b10);
        step();
        s_d_ready = 2'b11;
        #2;
        chk("t5_m_d_ready_high", 64'(m_d_ready), 64'd1);
        step();
        m_d_valid = 1'b0;

        // Asynchronous reset in the middle of a stall
        m_a_ready = 1'b0;
        set_a(1, 3'd4, 4'h5, 16'h0600, 32'h0);
        set_a(0, 3'd4, 4'h3, 16'h0700, 32'h0);
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_m_a_valid", 64'(m_a_valid), 64'd0);
        chk("t6_async_s_a_ready", 64'(s_a_ready), 64'd0);
        step();
        rst = 1'b0;
        m_a_ready = 1'b1;
        #2;
        chk("t6_after_reset_r0", 64'(s_a_ready), 64'b01);
        step();
        a_valid = '0;
        step();

        // Random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            m_a_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!a_hold[i]) begin
                    k = $urandom_range(2);
                    a_valid[i] = $urandom_range(1) == 1;
                    a_op[i]    = (k == 0) ? 3'd0 : (k == 1) ? 3'd1 : 3'd4;
                    a_par[i]   = 3'($urandom);
                    a_sz[i]    = 4'($urandom_range(2));
                    a_src[i]   = 4'($urandom);
                    a_addr[i]  = 16'($urandom);
                    a_msk[i]   = 4'($urandom);
                    a_dat[i]   = $urandom;
                end
            end
            if (!d_hold) begin
                if (pend_q.size() > 0 && $urandom_range(1) == 1) begin
                    k = $urandom_range(pend_q.size() - 1);
                    m_d_valid   = 1'b1;
                    m_d_source  = SW'(pend_q[k]);
                    m_d_opcode  = ($urandom_range(1) == 1) ? 3'd1 : 3'd0;
                    m_d_param   = 2'($urandom);
                    m_d_size    = 4'($urandom_range(2));
                    m_d_denied  = 1'($urandom);
                    m_d_corrupt = 1'($urandom);
                    m_d_data    = $urandom;
                end else begin
                    m_d_valid = 1'b0;
                end
            end
            s_d_ready = NREQ'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tl_ul_arbiter.md
Name: tl_ul_arbiter

Overview:
- N:1 TileLink-UL arbiter sharing one single-beat 32-bit slave port (CLINT, or any peer peripheral) between NREQ masters (harts, debug module).
- Channel A: round-robin arbitration with grant lock while a beat is stalled.
- Requester index is prepended to the source ID; channel D responses are demultiplexed on that prefix.
- Per-requester outstanding counters bound in-flight requests.

Parameters:
NREQ, 2, number of upstream masters (>=2)
TL_RS, 4, upstream source ID width
AW, 16, address width
MAX_OUT, 4, max in-flight requests per requester (>=1)
IW (localparam), $clog2(NREQ), index prefix width; downstream source width = TL_RS+IW

Ports:
arb_clock_i  in  1  clock
arb_reset_i  in  1  reset, asynchronous, active-high
s_a_opcode  in  NREQ*3  per-requester A opcode (requester i at [3i+2:3i], same packing for all s_* ports)
s_a_param  in  NREQ*3  A param
s_a_size  in  NREQ*4  A size
s_a_source  in  NREQ*TL_RS  A source
s_a_address  in  NREQ*AW  A address
s_a_mask  in  NREQ*4  A mask
s_a_data  in  NREQ*32  A data
s_a_valid  in  NREQ  A valid
s_a_ready  out  NREQ  A ready
s_d_opcode  out  NREQ*3  D opcode
s_d_param  out  NREQ*2  D param
s_d_size  out  NREQ*4  D size
s_d_source  out  NREQ*TL_RS  D source (prefix stripped)
s_d_denied  out  NREQ  D denied
s_d_data  out  NREQ*32  D data
s_d_corrupt  out  NREQ  D corrupt
s_d_valid  out  NREQ  D valid
s_d_ready  in  NREQ  D ready
m_a_opcode/param/size/address/mask/data  out  3/3/4/AW/4/32  downstream A fields of winner
m_a_source  out  TL_RS+IW  {winner index, winner source}
m_a_valid  out  1  downstream A valid
m_a_ready  in  1  downstream A ready
m_d_opcode/param/size/denied/data/corrupt  in  3/2/4/1/32/1  downstream D fields
m_d_source  in  TL_RS+IW  downstream D source
m_d_valid  in  1  downstream D valid
m_d_ready  out  1  downstream D ready

Behaviour:
- Reset state: rr_ptr=0, lock=0, lock_idx=0, all out_cnt[i]=0.
- Outputs during reset: s_a_ready=0, m_a_valid=0, s_d_valid=0, m_d_ready=0.
- Eligibility: elig[i] = s_a_valid[i] & (out_cnt[i] < MAX_OUT).
- Winner when lock=0: first eligible index scanning rr_ptr, rr_ptr+1, ... mod NREQ. Combinational; zero added latency.
- Winner when lock=1: lock_idx. Eligibility is ignored because the counter cannot have grown while the beat was stalled.
- Channel A outputs:
  - m_a_valid = lock | any(elig).
  - Fields are muxed from the winner.
  - s_a_ready[w] = m_a_ready & m_a_valid; all other s_a_ready = 0.
- Stall: m_a_valid & ~m_a_ready sets lock=1, lock_idx=w next cycle. Downstream A fields are held stable until accepted, so no switching occurs mid-stall.
- Fire (m_a_valid & m_a_ready):
  - lock <= 0.
  - rr_ptr <= (w+1) mod NREQ, with an explicit compare for non-power-of-2 NREQ.
  - out_cnt[w] increments.
- Channel D routing:
  - r = m_d_source[TL_RS+IW-1:TL_RS].
  - If r < NREQ: s_d_valid[r] = m_d_valid; all fields pass through; s_d_source[r] = low TL_RS bits; m_d_ready = s_d_ready[r]. Other s_d_valid = 0.
  - If r >= NREQ: m_d_ready = 1 and the response is dropped (sink-error guard).
  - Combinational, zero latency.
- D fire (m_d_valid & m_d_ready & r<NREQ): out_cnt[r] decrements.
- Same-requester A fire and D fire in one cycle: out_cnt unchanged.
- out_cnt width: $clog2(MAX_OUT+1). Never exceeds MAX_OUT and never underflows. A decrement at 0 is ignored; this is a protocol error, asserted in simulation only.
- Reset mid-stall: lock is cleared and counters are zeroed asynchronously. Any in-flight responses arriving after reset still route by prefix, with the decrement saturating at 0.
- No combinational path from m_a_ready to m_a_valid.

Test Plan:
- Requester 0 only, PutFullData addr 0x4000 data 0xA5A5A5A5, m_a_ready=1 -> same cycle m_a_valid=1, m_a_source={0,src}; D AccessAck with source {0,src} -> s_d_valid[0]=1, out_cnt[0] returns to 0.
- Both requesters valid continuously, m_a_ready=1, NREQ=2 -> grants alternate 0,1,0,1 over 4 cycles.
- Requester 1 wins with m_a_ready=0 for 3 cycles while requester 0 asserts valid -> m_a_* fields and source {1,src} stay constant; requester 1 accepted on cycle 4, then requester 0 granted.
- Requester 0 issues 4 Gets with m_d_valid held low (MAX_OUT=4) -> 5th not accepted (s_a_ready[0]=0) while requester 1 is still granted; one D return to requester 0 -> its 5th Get accepted the next cycle.
- m_d_valid with prefix 1 and s_d_ready[1]=0 -> m_d_ready=0, s_d_valid[0]=0; raise s_d_ready[1] -> handshake completes and out_cnt[1] decrements.
- Assert arb_reset_i asynchronously mid-stall with lock=1 -> m_a_valid drops immediately, all counters 0, rr_ptr=0 after release.
